ahb_transfer_control: RTL

AHB_TRANSFER_CONTROL -- requirements
Module: ahb_transfer_control

---
 rtl/ahb_transfer_control.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/ahb_transfer_control.sv
`default_nettype none
// ============================================================================
// Module  : ahb_transfer_control
// Purpose : AHB slave transfer FSM that turns address phases into backend requests
// Rev     : 1.0  initial release
// ============================================================================
module ahb_transfer_control #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          TIMEOUT   = 15
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  input  logic        HREADYIN,
  input  logic        bk_done,
  input  logic        bk_err,
  output logic        req_valid,
  output logic        req_write,
  output logic [11:0] req_addr,
  output logic [1:0]  req_size,
  output logic [31:0] req_wdata,
  output logic        enable,
  output logic        ready,
  output logic        error
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_WAIT  = 3'd2,
    S_RESP  = 3'd3,
    S_ERR   = 3'd4,
    S_ZERO  = 3'd5
  } state_t;

  localparam logic [3:0] C_TIMEOUT_LAST = 4'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [11:0] addr_q, addr_d;
  logic [1:0]  size_q, size_d;
  logic        write_q, write_d;
  logic        legal_q, legal_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        valid_q, valid_d;
  logic        enable_q, enable_d;
  logic        ready_q, ready_d;
  logic        error_q, error_d;

  logic w_accept;
  logic w_zero;
  logic w_legal;

  assign w_accept = HSEL & HREADYIN & HTRANS[1];
  assign w_zero   = HSEL & HREADYIN & ((HTRANS == 2'b00) | (HTRANS == 2'b01));

  // Legality is resolved at acceptance so an illegal transfer never raises req_valid.
  assign w_legal = (HADDR[31:12] == BASE_ADDR[31:12])
                 && (HSIZE <= 3'b010)
                 && !((HSIZE == 3'b001) && HADDR[0])
                 && !((HSIZE == 3'b010) && (HADDR[1:0] != 2'b00));

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    size_d  = size_q;
    write_d = write_q;
    legal_d = legal_q;
    wdata_d = wdata_q;
    cnt_d   = 4'd0;

    if ((state_q == S_CHECK) && legal_q && write_q) begin
      wdata_d = HWDATA;
    end

    if (w_accept) begin
      state_d = S_CHECK;
      addr_d  = HADDR[11:0];
      size_d  = HSIZE[1:0];
      write_d = HWRITE;
      legal_d = w_legal;
    end else begin
      case (state_q)
        S_CHECK: state_d = legal_q ? S_WAIT : S_ERR;
        S_WAIT: begin
          if (bk_err) begin
            state_d = S_ERR;
          end else if (bk_done) begin
            state_d = S_RESP;
          end else if (cnt_q == C_TIMEOUT_LAST) begin
            state_d = S_ERR;
          end else begin
            state_d = S_WAIT;
            cnt_d   = cnt_q + 4'd1;
          end
        end
        default: state_d = w_zero ? S_ZERO : S_IDLE;
      endcase
    end

    // Outputs are decoded from the next state so they leave the flops aligned with it.
    valid_d  = ((state_d == S_CHECK) && legal_d) || (state_d == S_WAIT);
    enable_d = (state_d != S_IDLE);
    ready_d  = (state_d == S_RESP) || (state_d == S_ZERO);
    error_d  = (state_d == S_ERR);
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q  <= S_IDLE;
      addr_q   <= 12'd0;
      size_q   <= 2'd0;
      write_q  <= 1'b0;
      legal_q  <= 1'b0;
      wdata_q  <= 32'd0;
      cnt_q    <= 4'd0;
      valid_q  <= 1'b0;
      enable_q <= 1'b0;
      ready_q  <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      size_q   <= size_d;
      write_q  <= write_d;
      legal_q  <= legal_d;
      wdata_q  <= wdata_d;
      cnt_q    <= cnt_d;
      valid_q  <= valid_d;
      enable_q <= enable_d;
      ready_q  <= ready_d;
      error_q  <= error_d;
    end
  end

  assign req_valid = valid_q;
  assign req_write = write_q;
  assign req_addr  = addr_q;
  assign req_size  = size_q;
  assign req_wdata = wdata_q;
  assign enable    = enable_q;
  assign ready     = ready_q;
  assign error     = error_q;

endmodule
`default_nettype wire
